cpu_execute_pipe: RTL

Parametrised execute stage for the pipelined CPU: forwarding muxes, immediate select, a single-cycle ALU, and an iterative shift-add multiplier. Registered E/M pipeline outputs and a persistent NZVC flag register. Sits between the register-read/E pipeline register and the memory stage. Drives a stall request to the hazard unit while a multi-cycle multiply is in flight.

---
 rtl/cpu_execute_pipe.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cpu_execute_pipe
// Purpose  : Execute stage: operand forwarding, immediate select, single-cycle
//            ALU, iterative shift-add multiplier, registered E/M outputs and a
//            persistent NZVC flag register. Requests an upstream stall while a
//            multiply is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_execute_pipe #(
  parameter int WIDTH      = 16,
  parameter int SHAMTWIDTH = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validE,
  input  logic             flushE,
  input  logic             flagWriteE,
  input  logic [2:0]       aluControlE,
  input  logic             data2SelectorE,
  input  logic [1:0]       data1ForwardSelectorE,
  input  logic [1:0]       data2ForwardSelectorE,
  input  logic [WIDTH-1:0] reg1ContentE,
  input  logic [WIDTH-1:0] reg2ContentE,
  input  logic [WIDTH-1:0] inmmediateE,
  input  logic [WIDTH-1:0] forwardM,
  input  logic [WIDTH-1:0] forwardWB,
  output logic             stallE,
  output logic             validM,
  output logic [WIDTH-1:0] aluOutputM,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_SHL = 3'd5;
  localparam logic [2:0] c_OP_SHR = 3'd6;
  localparam logic [2:0] c_OP_MUL = 3'd7;

  // Step counter only needs to reach WIDTH-1.
  localparam int             c_CNTW     = $clog2(WIDTH);
  localparam logic [c_CNTW-1:0] c_CNT_LAST = c_CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_MUL_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [2*WIDTH-1:0]     r_mulA;      // multiplicand, shifted left each step
  logic [WIDTH-1:0]       r_mulB;      // multiplier, shifted right each step
  logic [2*WIDTH-1:0]     r_product;
  logic [c_CNTW-1:0]      r_count;

  logic [WIDTH-1:0]       w_operandA;
  logic [WIDTH-1:0]       w_fwd2;
  logic [WIDTH-1:0]       w_operandB;
  logic [SHAMTWIDTH-1:0]  w_shamt;
  logic [WIDTH:0]         w_sum;
  logic [WIDTH:0]         w_diff;
  logic [WIDTH:0]         w_shl;       // bit WIDTH = last bit shifted out
  logic [WIDTH:0]         w_shr;       // bit 0     = last bit shifted out
  logic [WIDTH-1:0]       w_aluResult;
  logic                   w_aluV;
  logic                   w_aluC;
  logic [WIDTH-1:0]       w_mulLow;
  logic                   w_stall;
  logic                   w_startMul;
  logic                   w_aluDone;
  logic                   w_mulDone;

  assign w_shamt  = w_operandB[SHAMTWIDTH-1:0];
  assign w_sum    = {1'b0, w_operandA} + {1'b0, w_operandB};
  assign w_diff   = {1'b0, w_operandA} - {1'b0, w_operandB};
  assign w_shl    = {1'b0, w_operandA} << w_shamt;
  assign w_shr    = {w_operandA, 1'b0} >> w_shamt;
  assign w_mulLow = r_product[WIDTH-1:0];
  // Reset forces every output low, including the combinational stall.
  assign stallE   = w_stall & ~rst;

  // Forwarding muxes and immediate select; selector 3 aliases selector 0.
  always_comb begin
    w_operandA = reg1ContentE;
    w_fwd2     = reg2ContentE;
    case (data1ForwardSelectorE)
      2'd1:    w_operandA = forwardWB;
      2'd2:    w_operandA = forwardM;
      default: w_operandA = reg1ContentE;
    endcase
    case (data2ForwardSelectorE)
      2'd1:    w_fwd2 = forwardWB;
      2'd2:    w_fwd2 = forwardM;
      default: w_fwd2 = reg2ContentE;
    endcase
    w_operandB = data2SelectorE ? inmmediateE : w_fwd2;
  end

  // Single-cycle ALU with overflow and carry generation.
  always_comb begin
    w_aluResult = '0;
    w_aluV      = 1'b0;
    w_aluC      = 1'b0;
    case (aluControlE)
      c_OP_ADD: begin
        w_aluResult = w_sum[WIDTH-1:0];
        w_aluC      = w_sum[WIDTH];
        w_aluV      = (w_operandA[WIDTH-1] == w_operandB[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_operandA[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_aluResult = w_diff[WIDTH-1:0];
        w_aluC      = ~w_diff[WIDTH];   // carry means no borrow
        w_aluV      = (w_operandA[WIDTH-1] != w_operandB[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != w_operandA[WIDTH-1]);
      end
      c_OP_AND: w_aluResult = w_operandA & w_operandB;
      c_OP_OR:  w_aluResult = w_operandA | w_operandB;
      c_OP_XOR: w_aluResult = w_operandA ^ w_operandB;
      c_OP_SHL: begin
        w_aluResult = w_shl[WIDTH-1:0];
        w_aluC      = w_shl[WIDTH];
      end
      c_OP_SHR: begin
        w_aluResult = w_shr[WIDTH:1];
        w_aluC      = w_shr[0];
      end
      default: w_aluResult = '0;
    endcase
  end

  // Multiply sequencer: next state, stall request and completion strobes.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_startMul  = 1'b0;
    w_aluDone   = 1'b0;
    w_mulDone   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (validE && !flushE) begin
          if (aluControlE == c_OP_MUL) begin
            w_stall     = 1'b1;
            w_startMul  = 1'b1;
            w_nextState = S_MUL_BUSY;
          end else begin
            w_aluDone = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        if (flushE) begin
          w_nextState = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_count == c_CNT_LAST) w_nextState = S_MUL_DONE;
        end
      end
      S_MUL_DONE: begin
        w_nextState = S_IDLE;
        w_mulDone   = ~flushE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Operand capture and one shift-add step per cycle while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mulA    <= '0;
      r_mulB    <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else if (w_startMul) begin
      r_mulA    <= {{WIDTH{1'b0}}, w_operandA};
      r_mulB    <= w_operandB;
      r_product <= '0;
      r_count   <= '0;
    end else if (r_state == S_MUL_BUSY && !flushE) begin
      if (r_mulB[0]) r_product <= r_product + r_mulA;
      r_mulA  <= r_mulA << 1;
      r_mulB  <= r_mulB >> 1;
      r_count <= r_count + c_CNTW'(1);
    end
  end

  // E/M result register and NZVC flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validM     <= 1'b0;
      aluOutputM <= '0;
      N          <= 1'b0;
      Z          <= 1'b0;
      V          <= 1'b0;
      C          <= 1'b0;
    end else begin
      validM <= w_aluDone | w_mulDone;
      if (w_aluDone) begin
        aluOutputM <= w_aluResult;
        if (flagWriteE) begin
          N <= w_aluResult[WIDTH-1];
          Z <= (w_aluResult == '0);
          V <= w_aluV;
          C <= w_aluC;
        end
      end else if (w_mulDone) begin
        aluOutputM <= w_mulLow;
        if (flagWriteE) begin
          N <= w_mulLow[WIDTH-1];
          Z <= (w_mulLow == '0);
          V <= 1'b0;
          C <= |r_product[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule
`default_nettype wire
